// File: rtl/tdm_demux4_if.sv
// Bus bundle for the four-slot TDM demultiplexer.
// The master side drives the serial slot stream; the slave side (the demux)
// returns the assembled frame, the slot pointer and the status pulses.
interface tdm_demux4_if #(
    parameter int SLOT_W = 1
);
    logic [SLOT_W-1:0] in_s;
    logic              in_valid;
    logic              in_sync;
    logic [SLOT_W-1:0] out_00;
    logic [SLOT_W-1:0] out_01;
    logic [SLOT_W-1:0] out_10;
    logic [SLOT_W-1:0] out_11;
    logic              out_valid;
    logic [2:0]        out_select;
    logic              out_err;

    modport master (
        output in_s,
        output in_valid,
        output in_sync,
        input  out_00,
        input  out_01,
        input  out_10,
        input  out_11,
        input  out_valid,
        input  out_select,
        input  out_err
    );

    modport slave (
        input  in_s,
        input  in_valid,
        input  in_sync,
        output out_00,
        output out_01,
        output out_10,
        output out_11,
        output out_valid,
        output out_select,
        output out_err
    );
endinterface

// File: rtl/tdm_demux4.sv
// tdm_demux4: four-slot time-division demultiplexer.
// Serial beats are collected into a shadow frame; when the last beat of a
// frame arrives the whole frame is copied to the outputs at once and
// out_valid pulses for one cycle. Framing problems pulse out_err.
// Optional feature: define TDM_DEMUX4_PARITY_EN to add a fifth beat per
// frame carrying even parity (bitwise XOR of slots 0..3); a mismatch
// drops the frame with out_err instead of publishing it.
module tdm_demux4 #(
    parameter int SLOT_W = 1
) (
    input  logic         clock,
    input  logic         reset,
    tdm_demux4_if.slave  bus
);

`ifdef TDM_DEMUX4_PARITY_EN
    localparam int               SEL_W    = 3;
    localparam logic [SEL_W-1:0] LAST_SEL = 3'd4;
`else
    localparam int               SEL_W    = 2;
    localparam logic [SEL_W-1:0] LAST_SEL = 2'd3;
`endif

    typedef enum logic {
        WAIT_SYNC = 1'b0,
        RUN       = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [SEL_W-1:0]  select_q, select_d;
    logic [SLOT_W-1:0] shadow_q [4];
    logic [SLOT_W-1:0] shadow_d [4];
    logic [SLOT_W-1:0] out_q [4];
    logic [SLOT_W-1:0] out_d [4];
    logic              valid_q, valid_d;
    logic              err_q, err_d;

`ifdef TDM_DEMUX4_PARITY_EN
    logic [SLOT_W-1:0] parity_calc;

    // Expected parity beat for the frame currently held in the shadow slots.
    always_comb begin
        parity_calc = shadow_q[0] ^ shadow_q[1] ^ shadow_q[2] ^ shadow_q[3];
    end
`endif

    // All state (FSM, slot pointer, shadow frame, published frame, pulses).
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= WAIT_SYNC;
            select_q <= '0;
            valid_q  <= 1'b0;
            err_q    <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                shadow_q[i] <= '0;
                out_q[i]    <= '0;
            end
        end else begin
            state_q  <= state_d;
            select_q <= select_d;
            valid_q  <= valid_d;
            err_q    <= err_d;
            for (int i = 0; i < 4; i++) begin
                shadow_q[i] <= shadow_d[i];
                out_q[i]    <= out_d[i];
            end
        end
    end

    // Next-state decode: only accepted beats move anything; pulses default low.
    always_comb begin
        state_d  = state_q;
        select_d = select_q;
        shadow_d = shadow_q;
        out_d    = out_q;
        valid_d  = 1'b0;
        err_d    = 1'b0;

        if (bus.in_valid) begin
            unique case (state_q)
                WAIT_SYNC: begin
                    if (bus.in_sync) begin
                        shadow_d[0] = bus.in_s;
                        select_d    = 1;
                        state_d     = RUN;
                    end
                end

                RUN: begin
                    if (select_q == '0) begin
                        if (bus.in_sync) begin
                            shadow_d[0] = bus.in_s;
                            select_d    = 1;
                        end else begin
                            err_d   = 1'b1;
                            state_d = WAIT_SYNC;
                        end
                    end else if (bus.in_sync) begin
                        // Early sync: abandon the partial frame and restart on this beat.
                        err_d       = 1'b1;
                        shadow_d[0] = bus.in_s;
                        select_d    = 1;
                    end else if (select_q == LAST_SEL) begin
`ifdef TDM_DEMUX4_PARITY_EN
                        if (bus.in_s == parity_calc) begin
                            out_d   = shadow_q;
                            valid_d = 1'b1;
                        end else begin
                            err_d = 1'b1;
                        end
`else
                        out_d    = shadow_q;
                        out_d[3] = bus.in_s;
                        valid_d  = 1'b1;
`endif
                        select_d = '0;
                    end else begin
                        shadow_d[select_q[1:0]] = bus.in_s;
                        select_d                = select_q + 1'b1;
                    end
                end

                default: begin
                    state_d = WAIT_SYNC;
                end
            endcase
        end
    end

    assign bus.out_00    = out_q[0];
    assign bus.out_01    = out_q[1];
    assign bus.out_10    = out_q[2];
    assign bus.out_11    = out_q[3];
    assign bus.out_valid = valid_q;
    assign bus.out_err   = err_q;
`ifdef TDM_DEMUX4_PARITY_EN
    assign bus.out_select = select_q;
`else
    assign bus.out_select = {1'b0, select_q};
`endif

endmodule

// File: tb/tb_tdm_demux4.sv
// Testbench for tdm_demux4 (SLOT_W = 1). Directed beats push expected frame
// or error events into a scoreboard queue; a monitor pops one entry for every
// cycle the DUT shows out_valid or out_err. Parity vectors are compiled in
// when TDM_DEMUX4_PARITY_EN is defined.
module tb_tdm_demux4;

    typedef struct packed {
        logic       is_err;
        logic [3:0] frame;
    } event_t;

    logic clock;
    logic reset;
    int   vectors;
    int   miscompares;
    logic [3:0] last_frame;
    event_t     sb [$];

    tdm_demux4_if #(.SLOT_W(1)) bus ();

    tdm_demux4 #(.SLOT_W(1)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Compare a sampled value against its expected value and tally the result.
    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // Present one beat for exactly one clock edge, then return the bus to idle.
    task automatic applyStimulus(input logic s, input logic sync);
        bus.in_s     = s;
        bus.in_sync  = sync;
        bus.in_valid = 1'b1;
        @(posedge clock);
        #1;
        bus.in_valid = 1'b0;
        bus.in_sync  = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic expectFrame(input logic [3:0] f);
        event_t e;
        e.is_err   = 1'b0;
        e.frame    = f;
        sb.push_back(e);
        last_frame = f;
    endtask

    task automatic expectErr();
        event_t e;
        e.is_err = 1'b1;
        e.frame  = last_frame;
        sb.push_back(e);
    endtask

    // Send a full, correct frame {slot0,slot1,slot2,slot3} with optional idle gaps.
    task automatic sendFrame(input logic [3:0] f, input int gap);
        applyStimulus(f[3], 1'b1);
        if (gap > 0) idle(gap);
        applyStimulus(f[2], 1'b0);
        if (gap > 0) idle(gap);
        applyStimulus(f[1], 1'b0);
        if (gap > 0) idle(gap);
`ifdef TDM_DEMUX4_PARITY_EN
        applyStimulus(f[0], 1'b0);
        if (gap > 0) idle(gap);
        expectFrame(f);
        applyStimulus(^f, 1'b0);
`else
        expectFrame(f);
        applyStimulus(f[0], 1'b0);
`endif
    endtask

    // Monitor: every cycle with a status pulse must match the next scoreboard entry.
    always @(negedge clock) begin
        if (!reset && (bus.out_valid || bus.out_err)) begin
            event_t got;
            event_t exp_e;
            got.is_err = bus.out_err;
            got.frame  = {bus.out_00, bus.out_01, bus.out_10, bus.out_11};
            vectors++;
            if (bus.out_valid && bus.out_err) begin
                miscompares++;
                $display("[TB] FAIL valid_err_exclusive: got both high, expected one");
            end else if (sb.size() == 0) begin
                miscompares++;
                $display("[TB] FAIL unexpected_event: got err=%0b frame=%b, expected none", got.is_err, got.frame);
            end else begin
                exp_e = sb.pop_front();
                if (got !== exp_e) begin
                    miscompares++;
                    $display("[TB] FAIL event: got err=%0b frame=%b, expected err=%0b frame=%b",
                             got.is_err, got.frame, exp_e.is_err, exp_e.frame);
                end
            end
        end
    end

    initial begin
        vectors      = 0;
        miscompares  = 0;
        last_frame   = 4'b0000;
        reset        = 1'b1;
        bus.in_s     = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_sync  = 1'b0;
        idle(3);

        // Reset state
        checkOutput("reset_outputs", {28'd0, bus.out_00, bus.out_01, bus.out_10, bus.out_11}, 32'h0);
        checkOutput("reset_select", {29'd0, bus.out_select}, 32'd0);
        checkOutput("reset_pulses", {30'd0, bus.out_valid, bus.out_err}, 32'd0);
        reset = 1'b0;
        idle(2);

        // Unsynced beat while waiting for sync is silently dropped
        applyStimulus(1'b1, 1'b0);
        checkOutput("wait_discard_select", {29'd0, bus.out_select}, 32'd0);

        // Basic back-to-back frame 1,0,1,1
        applyStimulus(1'b1, 1'b1);
        checkOutput("select_after_sync", {29'd0, bus.out_select}, 32'd1);
        applyStimulus(1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0);
`ifdef TDM_DEMUX4_PARITY_EN
        applyStimulus(1'b1, 1'b0);
        checkOutput("select_at_parity", {29'd0, bus.out_select}, 32'd4);
        expectFrame(4'b1011);
        applyStimulus(1'b1, 1'b0);
`else
        expectFrame(4'b1011);
        applyStimulus(1'b1, 1'b0);
`endif
        checkOutput("select_wrap", {29'd0, bus.out_select}, 32'd0);
        idle(3);
        checkOutput("hold_basic", {28'd0, bus.out_00, bus.out_01, bus.out_10, bus.out_11}, 32'hB);

        // Same frame with 3 idle cycles between beats
        sendFrame(4'b1011, 3);
        idle(4);

        // Resync: 1(sync),1 then 0(sync),1,1,0
        applyStimulus(1'b1, 1'b1);
        applyStimulus(1'b1, 1'b0);
        expectErr();
        sendFrame(4'b0110, 0);
        idle(3);
        checkOutput("resync_outputs", {28'd0, bus.out_00, bus.out_01, bus.out_10, bus.out_11}, 32'h6);

        // Lost sync: unsynced beat at slot 0 while running
        expectErr();
        applyStimulus(1'b1, 1'b0);
        checkOutput("lost_sync_select", {29'd0, bus.out_select}, 32'd0);
        idle(2);
        checkOutput("lost_sync_hold", {28'd0, bus.out_00, bus.out_01, bus.out_10, bus.out_11}, 32'h6);
        // Back in WAIT_SYNC: another unsynced beat must not raise an error
        applyStimulus(1'b0, 1'b0);
        idle(2);

        // Reset in the middle of a frame
        applyStimulus(1'b1, 1'b1);
        applyStimulus(1'b1, 1'b0);
        reset = 1'b1;
        @(posedge clock);
        #1;
        checkOutput("midreset_select", {29'd0, bus.out_select}, 32'd0);
        checkOutput("midreset_outputs", {28'd0, bus.out_00, bus.out_01, bus.out_10, bus.out_11}, 32'h0);
        reset      = 1'b0;
        last_frame = 4'b0000;
        idle(1);
        sendFrame(4'b0001, 0);
        idle(3);
        checkOutput("after_reset_outputs", {28'd0, bus.out_00, bus.out_01, bus.out_10, bus.out_11}, 32'h1);

`ifdef TDM_DEMUX4_PARITY_EN
        // Parity: good parity publishes, bad parity errors and holds
        sendFrame(4'b1011, 0);
        idle(2);
        applyStimulus(1'b1, 1'b1);
        applyStimulus(1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0);
        applyStimulus(1'b1, 1'b0);
        expectErr();
        applyStimulus(1'b0, 1'b0);
        checkOutput("parity_err_select", {29'd0, bus.out_select}, 32'd0);
        idle(2);
        checkOutput("parity_err_hold", {28'd0, bus.out_00, bus.out_01, bus.out_10, bus.out_11}, 32'hB);
        // Still in RUN: a synced frame is accepted normally
        sendFrame(4'b0101, 0);
        idle(3);
`endif

        // Every expected pulse must have been observed
        checkOutput("scoreboard_drained", sb.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/tdm_demux4.md
TDM_DEMUX4 -- requirements
Module: tdm_demux4

Interface
REQ-001 The module SHALL have parameter SLOT_W, default 1, giving the bit width of each time slot.
REQ-002 Port clock SHALL be an input, 1 bit wide, and SHALL be the single clock; all state SHALL update on its rising edge.
REQ-003 Port reset SHALL be an input, 1 bit wide, asynchronous and active-high.
REQ-004 Port in_s SHALL be an input, SLOT_W bits wide, carrying the serial slot data.
REQ-005 Port in_valid SHALL be an input, 1 bit wide; when high, in_s and in_sync SHALL be accepted on that clock edge.
REQ-006 Port in_sync SHALL be an input, 1 bit wide, marking the first slot of a frame.
REQ-007 Ports out_00, out_01, out_10 and out_11 SHALL be outputs, SLOT_W bits each, carrying the last complete frame from slots 0 to 3.
REQ-008 Port out_valid SHALL be an output, 1 bit wide, pulsing for one cycle when a new frame is presented.
REQ-009 Port out_select SHALL be an output, 3 bits wide, holding the index of the next slot to be accepted.
REQ-010 Port out_err SHALL be an output, 1 bit wide, pulsing for one cycle on a framing or parity error.

Function
REQ-011 The FSM SHALL have two states, WAIT_SYNC and RUN.
REQ-012 In WAIT_SYNC, an accepted beat without in_sync SHALL be discarded with no error; an accepted beat with in_sync SHALL be stored as slot 0, set out_select=1, and move the FSM to RUN.
REQ-013 In RUN, each accepted beat SHALL be stored in the shadow slot[out_select], and out_select SHALL then increment.
REQ-014 A cycle with in_valid=0 SHALL change no state; gaps of any length between beats SHALL be legal.
REQ-015 On the edge that accepts the last frame beat (slot 3, or slot 4 with parity), out_00..out_11 SHALL load all four slots at once, out_select SHALL wrap to 0, and out_valid SHALL be high for the following cycle only.
REQ-016 Between frames, out_00..out_11 SHALL hold their values.
REQ-017 In RUN, an accepted beat at out_select=0 without in_sync SHALL pulse out_err, be discarded, and move the FSM to WAIT_SYNC.
REQ-018 In RUN, an accepted beat with in_sync at out_select!=0 SHALL pulse out_err, discard the partial frame, store that beat as slot 0, set out_select=1, and keep the FSM in RUN (resync).
REQ-019 out_valid and out_err SHALL never be high in the same cycle.
REQ-020 All outputs SHALL be registered, with no combinational path from any input to any output.

Reset
REQ-021 While reset is high, out_00..out_11 SHALL be 0, out_valid SHALL be 0, out_err SHALL be 0, out_select SHALL be 0, and the FSM SHALL be in WAIT_SYNC.
REQ-022 When reset is asserted mid-frame, the partial frame SHALL be discarded, and the first accepted beat after release SHALL be treated per WAIT_SYNC rules.

Configuration
REQ-023 When macro TDM_DEMUX4_PARITY_EN is defined, each frame SHALL be 5 beats, where slot 4 carries even parity equal to the bitwise XOR of slots 0 to 3.
REQ-024 With TDM_DEMUX4_PARITY_EN defined, on a parity match the module SHALL behave per REQ-015; on a mismatch it SHALL pulse out_err, SHALL NOT assert out_valid, SHALL hold the outputs, and SHALL stay in RUN with out_select=0.
REQ-025 When TDM_DEMUX4_PARITY_EN is undefined, each frame SHALL be 4 beats, there SHALL be no parity logic, and out_select[2] SHALL be constant 0.

Verification (SLOT_W=1)
REQ-026 Basic frame: with parity off, hold reset high, then drive beats 1(sync),0,1,1 back-to-back -> out_00=1, out_01=0, out_10=1, out_11=1, and out_valid=1 for exactly 1 cycle.
REQ-027 Gaps: drive the same frame with in_valid=0 for 3 cycles between each beat -> identical outputs and a single out_valid pulse.
REQ-028 Resync: drive 1(sync),1, then 0(sync),1,1,0 -> one out_err pulse on the third beat, then out_00..out_11=0,1,1,0 with out_valid.
REQ-029 Lost sync: after a good frame, drive an unsynced beat -> out_err pulse, out_select=0, FSM in WAIT_SYNC, and outputs held.
REQ-030 Reset mid-frame: drive 1(sync),1, assert reset for one cycle, then send a full frame 0(sync),0,0,1 -> outputs 0,0,0,1, with no out_err.
REQ-031 Parity: with TDM_DEMUX4_PARITY_EN defined, send 1,0,1,1 with parity 1 -> out_valid; resend with parity 0 -> out_err, no out_valid, and outputs unchanged.
